tdc_stream_sequencer: RTL and testbench
=======================================

# tdc_stream_sequencer

Transmit side of the timestamp stream consumed by the SiFH histogram builder. The block accepts one acquisition's worth of per-pixel TDC timestamps as a parallel word over a valid/ready handshake. It serialises them into the `wrEn`/`data` stream in the exact order the builder counts: data index fastest, then pixel, then acquisition. Empty slots are marked with the all-ones "no photon" code, and a mandatory idle gap follows every completed frame so the builder's internal frame reset can run.

## Interface
- `NP`, 16: timestamp width (Np).
- `DATA_NUM`, 2: timestamps per pixel per acquisition.
- `PIXEL_NUM`, 8: pixels per RAM.
- `ACQ_NUM`, 33333: acquisitions per frame.
- `FRAME_GAP`, 4: idle cycles after a frame's last beat (≥3).
- `clk`  in  1  clock.
- `res`  in  1  reset, asynchronous, active-high.
- `acq_valid`  in  1  upstream acquisition word valid.
- `acq_ready`  out  1  block can accept a word.
- `acq_data`  in  PIXEL_NUM·DATA_NUM·NP  timestamps; slot b = p·DATA_NUM+d at `[b·NP +: NP]`.
- `acq_hit`  in  PIXEL_NUM·DATA_NUM  bit b = 1: slot b holds a real photon.
- `wrEn`  out  1  stream beat valid (no backpressure).
- `data`  out  NP  stream timestamp.
- `frame_done`  out  1  one-cycle pulse, first GAP cycle.
- `busy`  out  1  state ≠ IDLE or hold buffer full.

## Operation
- Storage:
  - One-entry hold buffer (data + hit) and one shift register of BEATS = PIXEL_NUM·DATA_NUM slots.
  - `acq_ready = ~hold_full`, registered; it never depends combinationally on `acq_valid`.
- Accept: on an edge with `acq_valid && acq_ready`, the word is written to hold and `hold_full` is set.
- States:
  - IDLE: shift register empty.
  - SEND: emitting beats.
  - GAP: post-frame idle.
- Transfer hold→shift happens when `hold_full` and either:
  - state is IDLE, or
  - state is SEND on the last beat and the frame is not ending.
- On the transfer edge:
  - beat 0 is driven;
  - `hold_full` is cleared unless a new accept happens on the same edge (it cannot, since ready was low).
- Beat b:
  - `data = acq_hit[b] ? acq_data[b] : {NP{1'b1}}`;
  - `wrEn = 1`.
  - A real timestamp equal to all-ones is sent unchanged; the builder treats it as no-photon.
- Counters:
  - beat_idx 0..BEATS-1 wraps at each acquisition;
  - acq_idx 0..ACQ_NUM-1 increments on each last beat.
- SEND last beat:
  - acq_idx = ACQ_NUM-1 → GAP, acq_idx ← 0.
  - Otherwise, hold_full → next acquisition's beat 0 is driven on the next edge (contiguous).
  - Otherwise → IDLE, `wrEn` ← 0.
- GAP:
  - `wrEn = 0` for exactly FRAME_GAP cycles; `frame_done` = 1 in the first cycle only.
  - Accepts into hold are still allowed; no transfer occurs until GAP exits.
  - Exit goes to SEND if hold_full (transfer on the exit edge), else to IDLE.
- Within an acquisition `wrEn` never drops. Between acquisitions of one frame, gaps appear only when upstream starves.

## Timing
- Reset values:
  - `wrEn` 0; `data` all-ones; `frame_done` 0; `busy` 0.
  - `acq_ready` 1, with hold empty, state IDLE and all counters 0.
- Latency: acceptance at edge k in IDLE → transfer at edge k+1 → first beat (`wrEn` = 1) visible after edge k+1.
- Acquisition burst length: BEATS cycles.
- Frame length without starvation: ACQ_NUM·BEATS beats, then FRAME_GAP idle cycles.
- `acq_ready` falls the cycle after accept and rises the cycle after transfer.
- Reset asserted mid-burst or mid-gap:
  - all state is discarded and outputs take reset values immediately (asynchronous);
  - the partial frame is abandoned;
  - after release, the next accepted word is acquisition 0.
- Width rules:
  - beat_idx is $clog2(BEATS) bits; acq_idx is $clog2(ACQ_NUM) bits.
  - No arithmetic on timestamps.

## Structure
- Shared package `sifh_tx_pkg`:
  - state enum {IDLE, SEND, GAP};
  - BEATS and the counter-width localparams;
  - the NO_PHOTON all-ones constant (also used by the builder).
- Sub-module `acq_hold_reg`: one-entry valid/ready register for data+hit, exposing `full`, `ready` and a `pop` strobe.

## Test plan
All scenarios use NP=8, DATA_NUM=2, PIXEL_NUM=2, ACQ_NUM=3, FRAME_GAP=4.

- Single word, data {0x44,0x33,0x22,0x11} (slot 3..0), hit=4'b1111, accepted at edge k → beats 0x11,0x22,0x33,0x44 with `wrEn` = 1 after edges k+1..k+4; `wrEn` = 0 after k+5.
- hit=4'b0101 on the same data → stream 0x11,0xFF,0x33,0xFF.
- Three words presented back-to-back, `acq_valid` held high → 12 contiguous `wrEn` cycles; then `wrEn` = 0 for 4 cycles; `frame_done` high only in the first gap cycle.
- A word offered during GAP → `acq_ready` drops the cycle after acceptance; its beat 0 appears on the first cycle after the 4-cycle gap; acq_idx restarts at 0.
- `res` pulsed at beat 2 of acquisition 1 → `wrEn` 0 and `data` 0xFF immediately; after release, the following frame completes only after 3 fresh acquisitions.
- Upstream starved for 5 cycles between acquisitions 0 and 1 → `wrEn` low exactly during starvation; beat ordering and the frame_done position are unchanged.

Source files
------------

// File: rtl/sifh_tx_pkg.sv
// Shared definitions for the SiFH timestamp transmit path: sequencer states,
// default geometry, counter-width helper and the no-photon code.
package sifh_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int NP_DEF        = 16;
  localparam int DATA_NUM_DEF  = 2;
  localparam int PIXEL_NUM_DEF = 8;
  localparam int ACQ_NUM_DEF   = 33333;
  localparam int FRAME_GAP_DEF = 4;

  // Wide enough for any timestamp width; users slice the low NP bits.
  localparam logic [63:0] NO_PHOTON = '1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acq_hold_reg.sv
// One-entry valid/ready holding register for an acquisition word and its hit mask.
// Ready is a flop so upstream never sees a combinational path from its own valid.
module acq_hold_reg
  import sifh_tx_pkg::*;
#(
  parameter int DW = 32,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [HW-1:0] in_hit,
  input  logic          pop,
  output logic          ready,
  output logic          full,
  output logic [DW-1:0] out_data,
  output logic [HW-1:0] out_hit
);

  logic          full_q, full_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] data_q, data_d;
  logic [HW-1:0] hit_q, hit_d;
  logic          accept_s;

  always_comb begin
    accept_s = in_valid & ready_q;
    full_d   = full_q;
    data_d   = data_q;
    hit_d    = hit_q;
    if (accept_s) begin
      full_d = 1'b1;
      data_d = in_data;
      hit_d  = in_hit;
    end else if (pop) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
      hit_q   <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
    end
  end

  assign ready    = ready_q;
  assign full     = full_q;
  assign out_data = data_q;
  assign out_hit  = hit_q;

endmodule

// File: rtl/tdc_stream_sequencer.sv
// Serialises per-acquisition TDC timestamp words into the histogram builder's
// wrEn/data stream (slot fastest, then acquisition) with an idle gap per frame.
module tdc_stream_sequencer
  import sifh_tx_pkg::*;
#(
  parameter int NP        = NP_DEF,
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int ACQ_NUM   = ACQ_NUM_DEF,
  parameter int FRAME_GAP = FRAME_GAP_DEF
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             acq_valid,
  output logic                             acq_ready,
  input  logic [PIXEL_NUM*DATA_NUM*NP-1:0] acq_data,
  input  logic [PIXEL_NUM*DATA_NUM-1:0]    acq_hit,
  output logic                             wrEn,
  output logic [NP-1:0]                    data,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int BEATS  = PIXEL_NUM * DATA_NUM;
  localparam int WORD_W = BEATS * NP;
  localparam int BEAT_W = cnt_width(BEATS);
  localparam int ACQ_W  = cnt_width(ACQ_NUM);
  localparam int GAP_W  = cnt_width(FRAME_GAP);

  localparam logic [BEAT_W-1:0] BEAT_LAST    = BEAT_W'(BEATS - 1);
  localparam logic [ACQ_W-1:0]  ACQ_LAST     = ACQ_W'(ACQ_NUM - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST     = GAP_W'(FRAME_GAP - 1);
  localparam logic [NP-1:0]     NO_PHOTON_NP = NO_PHOTON[NP-1:0];

  tx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic [ACQ_W-1:0]  acq_idx_q, acq_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              wr_en_q, wr_en_d;
  logic [NP-1:0]     data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic              hold_ready_s, hold_full_s;
  logic [WORD_W-1:0] hold_data_s, masked_s;
  logic [BEATS-1:0]  hold_hit_s;
  logic              last_beat_s, frame_end_s, gap_last_s;
  logic              transfer_s, advance_s, accept_s, hold_next_s;

  acq_hold_reg #(
    .DW(WORD_W),
    .HW(BEATS)
  ) u_hold (
    .clk     (clk),
    .res     (res),
    .in_valid(acq_valid),
    .in_data (acq_data),
    .in_hit  (acq_hit),
    .pop     (transfer_s),
    .ready   (hold_ready_s),
    .full    (hold_full_s),
    .out_data(hold_data_s),
    .out_hit (hold_hit_s)
  );

  // Empty slots become the no-photon code as the word moves into the shifter.
  always_comb begin
    masked_s = '0;
    for (int b = 0; b < BEATS; b++) begin
      masked_s[b*NP +: NP] = hold_hit_s[b] ? hold_data_s[b*NP +: NP] : NO_PHOTON_NP;
    end
  end

  always_comb begin
    last_beat_s = (beat_idx_q == BEAT_LAST);
    frame_end_s = (acq_idx_q == ACQ_LAST);
    gap_last_s  = (gap_cnt_q == GAP_LAST);
    transfer_s  = hold_full_s & ((state_q == IDLE) |
                                 ((state_q == SEND) & last_beat_s & ~frame_end_s) |
                                 ((state_q == GAP) & gap_last_s));
    advance_s   = (state_q == SEND) & ~last_beat_s;
    accept_s    = acq_valid & hold_ready_s;
    hold_next_s = accept_s | (hold_full_s & ~transfer_s);

    wr_en_d    = transfer_s | advance_s;
    data_d     = transfer_s ? masked_s[NP-1:0] : (advance_s ? shift_q[NP-1:0] : data_q);
    shift_d    = transfer_s ? (masked_s >> NP) : (advance_s ? (shift_q >> NP) : shift_q);
    beat_idx_d = transfer_s ? '0 : (advance_s ? beat_idx_q + BEAT_W'(1) : beat_idx_q);

    state_d      = state_q;
    acq_idx_d    = acq_idx_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: state_d = transfer_s ? SEND : IDLE;
      SEND: begin
        if (!last_beat_s) begin
          state_d = SEND;
        end else if (frame_end_s) begin
          state_d      = GAP;
          acq_idx_d    = '0;
          gap_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          acq_idx_d = acq_idx_q + ACQ_W'(1);
          state_d   = transfer_s ? SEND : IDLE;
        end
      end
      GAP: begin
        if (gap_last_s) begin
          state_d = transfer_s ? SEND : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | hold_next_s;
  end

  // Sequencer state, counters and registered stream outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= IDLE;
      beat_idx_q   <= '0;
      acq_idx_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      wr_en_q      <= 1'b0;
      data_q       <= NO_PHOTON_NP;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      acq_idx_q    <= acq_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      wr_en_q      <= wr_en_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign acq_ready  = hold_ready_s;
  assign wrEn       = wr_en_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Directed bench for tdc_stream_sequencer with NP=8, 2x2 slots, 3 acquisitions per frame.
module tb_tdc_stream_sequencer;

  logic        clk;
  logic        res;
  logic        acq_valid;
  logic        acq_ready;
  logic [31:0] acq_data;
  logic [3:0]  acq_hit;
  logic        wrEn;
  logic [7:0]  data;
  logic        frame_done;
  logic        busy;

  int checks;
  int failures;

  tdc_stream_sequencer #(
    .NP(8), .DATA_NUM(2), .PIXEL_NUM(2), .ACQ_NUM(3), .FRAME_GAP(4)
  ) dut (
    .clk       (clk),
    .res       (res),
    .acq_valid (acq_valid),
    .acq_ready (acq_ready),
    .acq_data  (acq_data),
    .acq_hit   (acq_hit),
    .wrEn      (wrEn),
    .data      (data),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word just after an edge; it is taken on the next edge.
  task automatic send_word(input logic [31:0] w, input logic [3:0] h);
    acq_valid = 1'b1;
    acq_data  = w;
    acq_hit   = h;
    step();
    acq_valid = 1'b0;
  endtask

  task automatic expect_beats(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e [4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("%s_wr%0d", tag, i), {31'd0, wrEn}, 32'd1);
      chk($sformatf("%s_d%0d", tag, i), {24'd0, data}, {24'd0, e[i]});
    end
  endtask

  initial begin
    logic [7:0] s3 [12];
    checks    = 0;
    failures  = 0;
    res       = 1'b1;
    acq_valid = 1'b0;
    acq_data  = 32'd0;
    acq_hit   = 4'd0;
    step();
    step();
    chk("rst_wren",  {31'd0, wrEn},       32'd0);
    chk("rst_data",  {24'd0, data},       32'h0000_00FF);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_ready", {31'd0, acq_ready},  32'd1);
    res = 1'b0;
    step();

    // Single word, all hits: one-cycle latency then four contiguous beats.
    send_word(32'h4433_2211, 4'b1111);
    chk("s1_ready_fall", {31'd0, acq_ready}, 32'd0);
    chk("s1_lat_wren",   {31'd0, wrEn},      32'd0);
    chk("s1_busy",       {31'd0, busy},      32'd1);
    expect_beats("s1", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("s1_ready_rise", {31'd0, acq_ready}, 32'd1);
    step();
    chk("s1_end_wren", {31'd0, wrEn}, 32'd0);
    chk("s1_end_busy", {31'd0, busy}, 32'd0);

    send_word(32'h4433_2211, 4'b0101);
    expect_beats("s2", 8'h11, 8'hFF, 8'h33, 8'hFF);
    step();
    chk("s2_end_wren", {31'd0, wrEn}, 32'd0);

    // Third acquisition closes the frame.
    send_word(32'h4433_2211, 4'b1010);
    expect_beats("s2b", 8'hFF, 8'h22, 8'hFF, 8'h44);
    step();
    chk("s2b_gap_wren",  {31'd0, wrEn},       32'd0);
    chk("s2b_gap_fdone", {31'd0, frame_done}, 32'd1);
    chk("s2b_gap_busy",  {31'd0, busy},       32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("s2b_gap%0d_wren", i),  {31'd0, wrEn},       32'd0);
      chk($sformatf("s2b_gap%0d_fdone", i), {31'd0, frame_done}, 32'd0);
    end
    step();
    chk("s2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("s2b_idle_wren", {31'd0, wrEn}, 32'd0);

    // Three words back-to-back with valid held high: 12 contiguous beats.
    s3[0] = 8'h10; s3[1] = 8'h11; s3[2]  = 8'h12; s3[3]  = 8'h13;
    s3[4] = 8'h20; s3[5] = 8'h21; s3[6]  = 8'h22; s3[7]  = 8'h23;
    s3[8] = 8'h30; s3[9] = 8'h31; s3[10] = 8'hFF; s3[11] = 8'h33;
    acq_valid = 1'b1;
    acq_data  = 32'h1312_1110;
    acq_hit   = 4'b1111;
    step();
    acq_data = 32'h2322_2120;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("s3_wr%0d", i), {31'd0, wrEn}, 32'd1);
      chk($sformatf("s3_d%0d", i), {24'd0, data}, {24'd0, s3[i-1]});
      chk($sformatf("s3_fd%0d", i), {31'd0, frame_done}, 32'd0);
      if (i == 2) acq_data = 32'h33FF_3130;
      if (i == 6) acq_valid = 1'b0;
    end
    step();
    chk("s3_gap_wren",  {31'd0, wrEn},       32'd0);
    chk("s3_gap_fdone", {31'd0, frame_done}, 32'd1);

    // Word offered in the gap waits for the gap to finish.
    acq_valid = 1'b1;
    acq_data  = 32'h4342_4140;
    acq_hit   = 4'b1111;
    step();
    acq_valid = 1'b0;
    chk("s4_ready_fall", {31'd0, acq_ready},  32'd0);
    chk("s4_gap1_wren",  {31'd0, wrEn},       32'd0);
    chk("s4_gap1_fdone", {31'd0, frame_done}, 32'd0);
    step();
    chk("s4_gap2_wren", {31'd0, wrEn}, 32'd0);
    step();
    chk("s4_gap3_wren", {31'd0, wrEn}, 32'd0);
    step();
    chk("s4_b0_wren", {31'd0, wrEn}, 32'd1);
    chk("s4_b0_data", {24'd0, data}, 32'h0000_0040);
    acq_valid = 1'b1;
    acq_data  = 32'h5352_5150;
    step();
    acq_valid = 1'b0;
    chk("s4_b1_data", {24'd0, data}, 32'h0000_0041);
    step();
    chk("s4_b2_data", {24'd0, data}, 32'h0000_0042);
    step();
    chk("s4_b3_data", {24'd0, data}, 32'h0000_0043);
    step();
    chk("s5_b0_wren", {31'd0, wrEn}, 32'd1);
    chk("s5_b0_data", {24'd0, data}, 32'h0000_0050);
    step();
    step();
    chk("s5_b2_data", {24'd0, data}, 32'h0000_0052);

    // Asynchronous reset in the middle of acquisition 1.
    res = 1'b1;
    #1;
    chk("s5_rst_wren",  {31'd0, wrEn},       32'd0);
    chk("s5_rst_data",  {24'd0, data},       32'h0000_00FF);
    chk("s5_rst_busy",  {31'd0, busy},       32'd0);
    chk("s5_rst_ready", {31'd0, acq_ready},  32'd1);
    step();
    res = 1'b0;
    step();

    // Fresh frame: acquisition 0, five starved cycles, then acquisitions 1 and 2.
    send_word(32'h6362_6160, 4'b1111);
    expect_beats("s6a0", 8'h60, 8'h61, 8'h62, 8'h63);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("s6_starve%0d", i), {31'd0, wrEn}, 32'd0);
    end
    send_word(32'h7372_7170, 4'b0110);
    chk("s6_lat_wren", {31'd0, wrEn}, 32'd0);
    expect_beats("s6a1", 8'hFF, 8'h71, 8'h72, 8'hFF);
    step();
    chk("s6_a1_end_fdone", {31'd0, frame_done}, 32'd0);
    chk("s6_a1_end_wren",  {31'd0, wrEn},       32'd0);
    send_word(32'h8382_8180, 4'b1111);
    expect_beats("s6a2", 8'h80, 8'h81, 8'h82, 8'h83);
    step();
    chk("s6_gap_fdone", {31'd0, frame_done}, 32'd1);
    chk("s6_gap_wren",  {31'd0, wrEn},       32'd0);
    step();
    chk("s6_gap1_fdone", {31'd0, frame_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
